axi4_write_response_sequencer: RTL and testbench

Slave-side AXI4 write-response generator for the memory-port sink that faces the core's AXI4 master. It accepts AW requests, consumes the matching W bursts in order, and returns exactly one B response per burst, in AW order, with the request's ID echoed back. It also exports per-ID outstanding flags, so the master-side ID-tracking checker can be cross-checked against the responder's view of the interface.

---
 rtl/axi4_write_response_sequencer.sv | 135 +++++++++++++
 tb/tb_axi4_write_response_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_write_response_sequencer.sv
// Slave-side AXI4 write-response generator: queues AW IDs in order, retires one
// burst per w_last beat into a single-stage B register, and tracks per-ID outstanding bursts.
module axi4_write_response_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 2)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       aw_valid,
    output logic       aw_ready,
    input  logic [3:0] aw_id,
    input  logic       w_valid,
    output logic       w_ready,
    input  logic       w_last,
    output logic       b_valid,
    input  logic       b_ready,
    output logic [3:0] b_id,
    output logic [1:0] b_resp,
    output logic [7:0] id_pending,
    output logic       illegal_id_seen
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [4:0]       q_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             b_valid_q;
    logic [3:0]       b_id_q;
    logic [1:0]       b_resp_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q [8];

    logic       full, empty;
    logic       aw_fire, w_fire, last_fire, b_fire;
    logic [4:0] head;
    logic [7:0] inc, dec;

    assign full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign head  = q_mem_q[rd_ptr_q];

    // Readiness depends on registered state only; no same-cycle AW-to-W or pop-to-AW bypass.
    assign aw_ready = !full && !reset;
    assign w_ready  = !empty && (!b_valid_q || b_ready) && !reset;

    assign aw_fire   = aw_valid && aw_ready;
    assign w_fire    = w_valid && w_ready;
    assign last_fire = w_fire && w_last;
    assign b_fire    = b_valid_q && b_ready;

    always_comb begin
        count_d = count_q;
        case ({aw_fire, last_fire})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (aw_fire) begin
            q_mem_q[wr_ptr_q] <= {aw_id, aw_id[3]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            b_valid_q <= 1'b0;
            b_id_q    <= '0;
            b_resp_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (aw_fire) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (aw_id[3]) begin
                    illegal_q <= 1'b1;
                end
            end
            if (last_fire) begin
                rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
                b_valid_q <= 1'b1;
                b_id_q    <= head[4:1];
                b_resp_q  <= head[0] ? 2'b11 : 2'b00;
            end else if (b_fire) begin
                b_valid_q <= 1'b0;
            end
        end
    end

    // IDs 8-15 never touch the counters, so they stay invisible in id_pending.
    always_comb begin
        inc = '0;
        dec = '0;
        if (aw_fire && !aw_id[3]) begin
            inc[aw_id[2:0]] = 1'b1;
        end
        if (b_fire && !b_id_q[3]) begin
            dec[b_id_q[2:0]] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (inc[i] && !dec[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end else if (dec[i] && !inc[i]) begin
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        id_pending = '0;
        for (int i = 0; i < 8; i++) begin
            id_pending[i] = (cnt_q[i] != '0);
        end
    end

    assign b_valid         = b_valid_q;
    assign b_id            = b_id_q;
    assign b_resp          = b_resp_q;
    assign illegal_id_seen = illegal_q;

endmodule

// File: tb/tb_axi4_write_response_sequencer.sv
// Directed bench for axi4_write_response_sequencer: drivers push expected B responses,
// a negedge monitor pops and compares them on every B handshake.
module tb_axi4_write_response_sequencer;

    logic       clock;
    logic       reset;
    logic       aw_valid;
    logic       aw_ready;
    logic [3:0] aw_id;
    logic       w_valid;
    logic       w_ready;
    logic       w_last;
    logic       b_valid;
    logic       b_ready;
    logic [3:0] b_id;
    logic [1:0] b_resp;
    logic [7:0] id_pending;
    logic       illegal_id_seen;

    logic [5:0] exp_q[$];
    int         total;
    int         bad;

    axi4_write_response_sequencer #(.FIFO_DEPTH(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .aw_valid        (aw_valid),
        .aw_ready        (aw_ready),
        .aw_id           (aw_id),
        .w_valid         (w_valid),
        .w_ready         (w_ready),
        .w_last          (w_last),
        .b_valid         (b_valid),
        .b_ready         (b_ready),
        .b_id            (b_id),
        .b_resp          (b_resp),
        .id_pending      (id_pending),
        .illegal_id_seen (illegal_id_seen)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // drivers
    task automatic do_aw(input logic [3:0] id, input logic [1:0] resp);
        int n = 0;
        aw_valid = 1'b1;
        aw_id    = id;
        #1;
        while (!aw_ready && n < 50) begin
            tick();
            n++;
        end
        check("aw_ready_wait", aw_ready, 1);
        if (aw_ready) begin
            exp_q.push_back({id, resp});
        end
        tick();
        aw_valid = 1'b0;
    endtask

    task automatic do_w(input logic last);
        int n = 0;
        w_valid = 1'b1;
        w_last  = last;
        #1;
        while (!w_ready && n < 50) begin
            tick();
            n++;
        end
        check("w_ready_wait", w_ready, 1);
        tick();
        w_valid = 1'b0;
        w_last  = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        logic [5:0] e;
        if (!reset && b_valid && b_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected actual=id%0d/resp%0d required=none", b_id, b_resp);
            end else begin
                e = exp_q.pop_front();
                check("b_response", {26'd0, b_id, b_resp}, {26'd0, e});
            end
        end
    end

    initial begin
        logic ok;
        reset    = 1'b1;
        aw_valid = 1'b0;
        aw_id    = '0;
        w_valid  = 1'b0;
        w_last   = 1'b0;
        b_ready  = 1'b0;
        total    = 0;
        bad      = 0;
        #1;
        check("rst_b_valid", b_valid, 0);
        check("rst_b_id", b_id, 0);
        check("rst_b_resp", b_resp, 0);
        check("rst_id_pending", id_pending, 0);
        check("rst_illegal", illegal_id_seen, 0);
        check("rst_aw_ready", aw_ready, 0);
        check("rst_w_ready", w_ready, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        tick();
        check("idle_aw_ready", aw_ready, 1);
        check("idle_w_ready", w_ready, 0);

        // single burst, no AW-to-W bypass
        b_ready  = 1'b1;
        aw_valid = 1'b1;
        aw_id    = 4'd3;
        w_valid  = 1'b1;
        w_last   = 1'b0;
        #1;
        check("nobypass_w_ready", w_ready, 0);
        check("single_aw_ready", aw_ready, 1);
        exp_q.push_back({4'd3, 2'b00});
        tick();
        aw_valid = 1'b0;
        check("single_pending_set", id_pending, 8'h08);
        do_w(1'b0);
        do_w(1'b0);
        do_w(1'b0);
        check("single_no_early_b", b_valid, 0);
        do_w(1'b1);
        check("single_b_valid", b_valid, 1);
        check("single_b_id", b_id, 3);
        check("single_b_resp", b_resp, 0);
        check("single_pending_held", id_pending, 8'h08);
        tick();
        check("single_pending_clr", id_pending, 0);
        check("single_b_done", b_valid, 0);

        // queue full
        b_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_aw(4'(i), 2'b00);
        end
        aw_valid = 1'b1;
        aw_id    = 4'd4;
        #1;
        check("full_aw_ready", aw_ready, 0);
        tick();
        tick();
        check("full_aw_ready_held", aw_ready, 0);
        check("full_pending", id_pending, 8'h0f);
        b_ready = 1'b1;
        do_w(1'b1);
        check("full_aw_after_pop", aw_ready, 1);
        do_aw(4'd4, 2'b00);
        for (int i = 0; i < 4; i++) begin
            do_w(1'b1);
        end
        tick();
        check("full_drained_pending", id_pending, 0);

        // illegal id
        do_aw(4'd9, 2'b11);
        check("illegal_pending_a", id_pending, 0);
        check("illegal_seen", illegal_id_seen, 1);
        do_w(1'b1);
        check("illegal_b_id", b_id, 9);
        check("illegal_b_resp", b_resp, 2'b11);
        tick();
        check("illegal_pending_b", id_pending, 0);

        // backpressure
        b_ready = 1'b0;
        do_aw(4'd1, 2'b00);
        do_aw(4'd2, 2'b00);
        do_w(1'b1);
        w_valid = 1'b1;
        w_last  = 1'b1;
        #1;
        check("bp_w_ready", w_ready, 0);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!(b_valid && b_id == 4'd1 && b_resp == 2'b00 && !w_ready)) ok = 1'b0;
        end
        check("bp_stable", ok, 1);
        b_ready = 1'b1;
        do_w(1'b1);
        check("bp_second_id", b_id, 2);
        tick();
        check("bp_pending_clr", id_pending, 0);

        // same-ID overlap of AW accept and B handshake
        b_ready = 1'b0;
        do_aw(4'd5, 2'b00);
        do_aw(4'd5, 2'b00);
        do_w(1'b1);
        check("ovl_pending_pre", id_pending, 8'h20);
        b_ready = 1'b1;
        do_aw(4'd5, 2'b00);
        check("ovl_pending", id_pending, 8'h20);
        do_w(1'b1);
        tick();
        check("ovl_pending_mid", id_pending, 8'h20);
        do_w(1'b1);
        tick();
        check("ovl_pending_done", id_pending, 0);
        check("illegal_sticky", illegal_id_seen, 1);

        // reset mid-burst
        do_aw(4'd6, 2'b00);
        do_w(1'b0);
        do_w(1'b0);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_b_valid", b_valid, 0);
        check("mid_rst_pending", id_pending, 0);
        check("mid_rst_illegal", illegal_id_seen, 0);
        check("mid_rst_aw_ready", aw_ready, 0);
        check("mid_rst_w_ready", w_ready, 0);
        tick();
        tick();
        @(negedge clock);
        reset = 1'b0;
        tick();
        w_valid = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w_last = 1'(i % 2);
            #1;
            if (b_valid || w_ready) ok = 1'b0;
            tick();
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
        check("post_rst_quiet", ok, 1);
        check("post_rst_aw_ready", aw_ready, 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
